parity_frame_ctrl: RTL and testbench

//  Sequencer for the 4-bit-data + parity-bit checker. Deserialises a bit stream into

---
 rtl/parity_pkg.sv | 15 +
 rtl/parity_xor_n.sv | 12 +
 rtl/parity_frame_ctrl.sv | 142 ++++++++++++++
 tb/tb_parity_frame_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared encodings for the serial parity frame controller.
// States and parity-sense constants used by the controller and its bench.
package parity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_xor_n.sv
// Combinational XOR reduction of an N-bit vector.
// Used to fold data plus received parity bit into one check bit.
module parity_xor_n #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_vec,
  output logic         o_par
);

  assign o_par = ^i_vec;

endmodule

// File: rtl/parity_frame_ctrl.sv
// Deserialises data+parity frames, checks parity, presents results
// on a valid/ready port and keeps frame / error statistics.
module parity_frame_ctrl
  import parity_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ODD    = 0,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin_valid,
  input  logic              sin_start,
  input  logic              sin_bit,
  output logic              sin_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int IDX_W = $clog2(DATA_W) + 1;
  localparam state_t ST_FIRST =
    (DATA_W == 1) ? ST_PAR : ST_DATA;
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic SENSE =
    (ODD != 0) ? PAR_ODD : PAR_EVEN;

  state_t            r_state;
  state_t            w_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_err;
  logic              r_out_valid;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic [CNT_W-1:0]  r_err_cnt;

  logic w_acc;
  logic w_new;
  logic w_par;
  logic w_xor;
  logic w_err;

  assign sin_ready = (r_state != ST_HOLD);
  assign w_acc     = sin_valid & sin_ready;
  assign w_new     = w_acc & sin_start;
  assign w_par     = w_acc & ~sin_start &
                     (r_state == ST_PAR);

  parity_xor_n #(
    .N (DATA_W + 1)
  ) u_xor (
    .i_vec ({sin_bit, r_data}),
    .o_par (w_xor)
  );

  assign w_err = w_xor ^ SENSE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  // A start bit restarts the frame from any receiving state.
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_new) w_nxt = ST_FIRST;
      end
      ST_DATA: begin
        if (w_new)
          w_nxt = ST_FIRST;
        else if (w_acc && r_idx == IDX_LAST)
          w_nxt = ST_PAR;
      end
      ST_PAR: begin
        if (w_new)      w_nxt = ST_FIRST;
        else if (w_acc) w_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_data <= '0;
    end else if (w_new) begin
      r_data <= DATA_W'(sin_bit);
      r_idx  <= IDX_W'(1);
    end else if (w_acc && r_state == ST_DATA) begin
      for (int i = 0; i < DATA_W; i++)
        if (r_idx == IDX_W'(i)) r_data[i] <= sin_bit;
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_par) begin
      r_out_data  <= r_data;
      r_out_err   <= w_err;
      r_out_valid <= 1'b1;
    end else if (r_state == ST_HOLD && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (clr_cnt) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (w_par) begin
      r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      if (w_err && r_err_cnt != CNT_MAX)
        r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;
  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Directed bench: even, odd and 2-bit-counter controllers share
// one serial stream; table vectors plus corner sequences.
module tb_parity_frame_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sin_valid = 1'b0;
  logic sin_start = 1'b0;
  logic sin_bit = 1'b0;
  logic out_ready = 1'b1;
  logic clr_cnt = 1'b0;

  logic       e_rdy, e_vld, e_err;
  logic [3:0] e_data;
  logic [7:0] e_fc, e_ec;
  logic       o_rdy, o_vld, o_err;
  logic [3:0] o_data;
  logic [7:0] o_fc, o_ec;
  logic       c_rdy, c_vld, c_err;
  logic [3:0] c_data;
  logic [1:0] c_fc, c_ec;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] d;
    logic       p;
    logic       err;
    logic       err_odd;
  } vec_t;

  vec_t tv[7];

  always #5 clk = ~clk;

  parity_frame_ctrl #(.DATA_W(4), .ODD(0), .CNT_W(8)) u_even (
    .clk(clk), .rst_n(rst_n),
    .sin_valid(sin_valid), .sin_start(sin_start),
    .sin_bit(sin_bit), .sin_ready(e_rdy),
    .out_valid(e_vld), .out_ready(out_ready),
    .out_data(e_data), .out_err(e_err),
    .clr_cnt(clr_cnt),
    .frame_cnt(e_fc), .err_cnt(e_ec)
  );

  parity_frame_ctrl #(.DATA_W(4), .ODD(1), .CNT_W(8)) u_odd (
    .clk(clk), .rst_n(rst_n),
    .sin_valid(sin_valid), .sin_start(sin_start),
    .sin_bit(sin_bit), .sin_ready(o_rdy),
    .out_valid(o_vld), .out_ready(out_ready),
    .out_data(o_data), .out_err(o_err),
    .clr_cnt(clr_cnt),
    .frame_cnt(o_fc), .err_cnt(o_ec)
  );

  parity_frame_ctrl #(.DATA_W(4), .ODD(0), .CNT_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n),
    .sin_valid(sin_valid), .sin_start(sin_start),
    .sin_bit(sin_bit), .sin_ready(c_rdy),
    .out_valid(c_vld), .out_ready(out_ready),
    .out_data(c_data), .out_err(c_err),
    .clr_cnt(clr_cnt),
    .frame_cnt(c_fc), .err_cnt(c_ec)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic put(input logic b, input logic s);
    sin_valid = 1'b1;
    sin_bit   = b;
    sin_start = s;
    @(negedge clk);
    sin_valid = 1'b0;
    sin_start = 1'b0;
  endtask

  task automatic frame(input logic [3:0] d, input logic p);
    put(d[0], 1'b1);
    put(d[1], 1'b0);
    put(d[2], 1'b0);
    put(d[3], 1'b0);
    put(p, 1'b0);
  endtask

  task automatic pulse_clr();
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int exp_fc, exp_ec, exp_oec;

    tv[0] = '{4'b1101, 1'b1, 1'b0, 1'b1};
    tv[1] = '{4'b1101, 1'b0, 1'b1, 1'b0};
    tv[2] = '{4'b0000, 1'b0, 1'b0, 1'b1};
    tv[3] = '{4'b1111, 1'b1, 1'b1, 1'b0};
    tv[4] = '{4'b1010, 1'b0, 1'b0, 1'b1};
    tv[5] = '{4'b0110, 1'b1, 1'b1, 1'b0};
    tv[6] = '{4'b1000, 1'b1, 1'b0, 1'b1};

    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", 32'(e_vld), 0);
    chk("rst_data", 32'(e_data), 0);
    chk("rst_err", 32'(e_err), 0);
    chk("rst_ready", 32'(e_rdy), 1);
    chk("rst_fc", 32'(e_fc), 0);
    chk("rst_ec", 32'(e_ec), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // bits 1,0,1,1 + parity 1, result one cycle after parity
    put(1'b1, 1'b1);
    put(1'b0, 1'b0);
    put(1'b1, 1'b0);
    put(1'b1, 1'b0);
    chk("t1_pre_valid", 32'(e_vld), 0);
    put(1'b1, 1'b0);
    chk("t1_valid", 32'(e_vld), 1);
    chk("t1_data", 32'(e_data), 32'hD);
    chk("t1_err", 32'(e_err), 0);
    chk("t1_fc", 32'(e_fc), 1);
    chk("t1_ec", 32'(e_ec), 0);
    @(negedge clk);
    chk("t1_drop", 32'(e_vld), 0);

    pulse_clr();
    exp_fc = 0; exp_ec = 0; exp_oec = 0;
    for (int i = 0; i < 7; i++) begin
      frame(tv[i].d, tv[i].p);
      exp_fc++;
      exp_ec  += int'(tv[i].err);
      exp_oec += int'(tv[i].err_odd);
      chk($sformatf("tv%0d_valid", i), 32'(e_vld), 1);
      chk($sformatf("tv%0d_data", i), 32'(e_data), 32'(tv[i].d));
      chk($sformatf("tv%0d_err", i), 32'(e_err), 32'(tv[i].err));
      chk($sformatf("tv%0d_odata", i), 32'(o_data), 32'(tv[i].d));
      chk($sformatf("tv%0d_oerr", i), 32'(o_err), 32'(tv[i].err_odd));
      chk($sformatf("tv%0d_ovalid", i), 32'(o_vld), 1);
      chk($sformatf("tv%0d_fc", i), 32'(e_fc), 32'(exp_fc));
      chk($sformatf("tv%0d_ec", i), 32'(e_ec), 32'(exp_ec));
      chk($sformatf("tv%0d_ofc", i), 32'(o_fc), 32'(exp_fc));
      chk($sformatf("tv%0d_oec", i), 32'(o_ec), 32'(exp_oec));
      chk($sformatf("tv%0d_rdy_hold", i), 32'(e_rdy), 0);
      @(negedge clk);
      chk($sformatf("tv%0d_done", i), 32'(e_vld), 0);
      chk($sformatf("tv%0d_rdy", i), 32'(e_rdy), 1);
      chk($sformatf("tv%0d_ordy", i), 32'(o_rdy), 1);
    end

    // consumer stalls: result held, input ignored
    out_ready = 1'b0;
    frame(4'b1101, 1'b1);
    exp_fc++;
    for (int k = 0; k < 5; k++) begin
      put(1'(k), 1'b1);
      chk("t3_valid", 32'(e_vld), 1);
      chk("t3_data", 32'(e_data), 32'hD);
      chk("t3_err", 32'(e_err), 0);
      chk("t3_rdy", 32'(e_rdy), 0);
    end
    chk("t3_fc", 32'(e_fc), 32'(exp_fc));
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_valid", 32'(e_vld), 0);
    chk("t3_release_rdy", 32'(e_rdy), 1);

    // resync after two data bits
    put(1'b1, 1'b1);
    put(1'b1, 1'b0);
    chk("t4_no_out", 32'(e_vld), 0);
    frame(4'b0000, 1'b0);
    exp_fc++;
    chk("t4_valid", 32'(e_vld), 1);
    chk("t4_data", 32'(e_data), 0);
    chk("t4_err", 32'(e_err), 0);
    chk("t4_fc", 32'(e_fc), 32'(exp_fc));
    @(negedge clk);

    // narrow counters: wrap and saturate
    pulse_clr();
    repeat (5) begin
      frame(4'b1101, 1'b0);
      chk("t5_cvalid", 32'(c_vld), 1);
      chk("t5_cerr", 32'(c_err), 1);
      chk("t5_cdata", 32'(c_data), 32'hD);
      @(negedge clk);
      chk("t5_crdy", 32'(c_rdy), 1);
    end
    chk("t5_c_ec", 32'(c_ec), 3);
    chk("t5_c_fc", 32'(c_fc), 1);
    chk("t5_e_ec", 32'(e_ec), 5);
    chk("t5_e_fc", 32'(e_fc), 5);
    put(1'b1, 1'b1);
    put(1'b0, 1'b0);
    put(1'b1, 1'b0);
    put(1'b1, 1'b0);
    clr_cnt = 1'b1;
    put(1'b0, 1'b0);
    clr_cnt = 1'b0;
    chk("t5_clr_valid", 32'(e_vld), 1);
    chk("t5_clr_c_fc", 32'(c_fc), 0);
    chk("t5_clr_c_ec", 32'(c_ec), 0);
    chk("t5_clr_e_fc", 32'(e_fc), 0);
    chk("t5_clr_e_ec", 32'(e_ec), 0);
    @(negedge clk);

    // reset mid-frame and while holding a result
    frame(4'b1101, 1'b0);
    @(negedge clk);
    chk("t6_pre_fc", 32'(e_fc), 1);
    put(1'b1, 1'b1);
    put(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_data_rst_valid", 32'(e_vld), 0);
    chk("t6_data_rst_rdy", 32'(e_rdy), 1);
    chk("t6_data_rst_fc", 32'(e_fc), 0);
    chk("t6_data_rst_ec", 32'(e_ec), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    frame(4'b1101, 1'b0);
    chk("t6_hold_valid", 32'(e_vld), 1);
    chk("t6_hold_rdy", 32'(e_rdy), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_hold_rst_valid", 32'(e_vld), 0);
    chk("t6_hold_rst_data", 32'(e_data), 0);
    chk("t6_hold_rst_err", 32'(e_err), 0);
    chk("t6_hold_rst_rdy", 32'(e_rdy), 1);
    chk("t6_hold_rst_fc", 32'(e_fc), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    frame(4'b1011, 1'b1);
    chk("t6_clean_valid", 32'(e_vld), 1);
    chk("t6_clean_data", 32'(e_data), 32'hB);
    chk("t6_clean_err", 32'(e_err), 0);
    chk("t6_clean_fc", 32'(e_fc), 1);
    @(negedge clk);
    chk("t6_clean_done", 32'(e_vld), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
